// File: rtl/loop_replay_buf_pkg.sv
// Loop replay buffer: shared state type, lane geometry and lane-mask helpers.
// The mask helpers are also used by the loop address table stage.
package loop_replay_buf_pkg;

    localparam int LANE_W = 16;
    localparam int LANES  = 4;
    localparam int BW     = LANE_W * LANES;

    typedef enum logic [1:0] {
        ST_PASS,
        ST_CAPTURE,
        ST_ARMED,
        ST_REPLAY
    } lrb_state_e;

    // Mask bit 3 is lane0 (oldest), bit 0 is lane3.
    function automatic logic [2:0] mask2cnt(input logic [LANES-1:0] m);
        logic [2:0] c;
        c = '0;
        for (int i = 0; i < LANES; i++) begin
            c = c + {2'b00, m[i]};
        end
        return c;
    endfunction

    function automatic logic [LANES-1:0] cnt2mask(input logic [2:0] n);
        logic [LANES-1:0] m;
        case (n)
            3'd0:    m = 4'b0000;
            3'd1:    m = 4'b1000;
            3'd2:    m = 4'b1100;
            3'd3:    m = 4'b1110;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [BW-1:0] lane_bits(input logic [LANES-1:0] m);
        logic [BW-1:0] b;
        b = '0;
        for (int i = 0; i < LANES; i++) begin
            b[i*LANE_W +: LANE_W] = {LANE_W{m[i]}};
        end
        return b;
    endfunction

endpackage

// File: rtl/loop_replay_buf_mem.sv
// Loop body storage: compacting 4-lane write, 4-lane read at rd_ptr_i
// wrapping within the captured body length.
module lrb_mem
    import loop_replay_buf_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int CW    = 7
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [CW-1:0]    wr_ptr_i,
    input  logic [LANES-1:0] wr_mask_i,
    input  logic [BW-1:0]    wr_inst_i,
    input  logic [BW-1:0]    wr_pc_i,
    input  logic [CW-1:0]    rd_ptr_i,
    input  logic [CW-1:0]    len_i,
    output logic [BW-1:0]    rd_inst_o,
    output logic [BW-1:0]    rd_pc_o
);

    localparam int AW = $clog2(DEPTH);

    logic [LANE_W-1:0] inst_mem [DEPTH];
    logic [LANE_W-1:0] pc_mem   [DEPTH];
    logic [CW-1:0]     waddr    [LANES];
    logic [CW:0]       raddr    [LANES];
    logic [CW-1:0]     woff;
    logic              unused_hi;

    // Each valid lane lands right after the previous valid lane.
    always_comb begin
        woff = '0;
        for (int k = 0; k < LANES; k++) begin
            waddr[k] = wr_ptr_i + woff;
            woff = woff + CW'(wr_mask_i[LANES-1-k]);
        end
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int k = 0; k < LANES; k++) begin
                if (wr_mask_i[LANES-1-k]) begin
                    inst_mem[waddr[k][AW-1:0]] <=
                        wr_inst_i[(LANES-1-k)*LANE_W +: LANE_W];
                    pc_mem[waddr[k][AW-1:0]] <=
                        wr_pc_i[(LANES-1-k)*LANE_W +: LANE_W];
                end
            end
        end
    end

    always_comb begin
        rd_inst_o = '0;
        rd_pc_o   = '0;
        for (int k = 0; k < LANES; k++) begin
            raddr[k] = {1'b0, rd_ptr_i} + (CW+1)'(k);
            if (raddr[k] >= {1'b0, len_i}) begin
                raddr[k] = raddr[k] - {1'b0, len_i};
            end
            rd_inst_o[(LANES-1-k)*LANE_W +: LANE_W] =
                inst_mem[raddr[k][AW-1:0]];
            rd_pc_o[(LANES-1-k)*LANE_W +: LANE_W] =
                pc_mem[raddr[k][AW-1:0]];
        end
    end

    always_comb begin
        unused_hi = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            unused_hi = unused_hi ^ (^waddr[k]) ^ (^raddr[k]);
        end
    end

endmodule

// File: rtl/loop_replay_buf.sv
// Loop replay buffer: passes fetch bundles to decode, captures loop bodies
// and replays them to decode while fetch is stalled.
module loop_replay_buf
    import loop_replay_buf_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int CW    = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bndl_vld_in,
    input  logic [BW-1:0]    inst_in,
    input  logic [BW-1:0]    pc_in,
    input  logic [LANES-1:0] inst_valid_in,
    input  logic             loop_strt_in,
    input  logic             stll_ftch_in,
    input  logic             fnsh_unrll_in,
    input  logic             mis_pred_in,
    input  logic             out_rdy_in,
    output logic [BW-1:0]    out_inst,
    output logic [BW-1:0]    out_pc,
    output logic [LANES-1:0] out_valid,
    output logic             out_replay,
    output logic             ups_stall_out,
    output logic             rply_done_out
);

    lrb_state_e state_q, state_d;

    logic [CW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     len_q, len_d;
    logic [LANE_W-1:0] spc_q, spc_d;
    logic              fnsh_q, fnsh_d;
    logic [BW-1:0]     oinst_q, oinst_d;
    logic [BW-1:0]     opc_q, opc_d;
    logic [LANES-1:0]  ovld_q, ovld_d;
    logic              orep_q, orep_d;
    logic              done_q, done_d;

    logic              out_free, stall, accept;
    logic [2:0]        in_cnt, rp_cnt;
    logic [CW:0]       cap_sum;
    logic              cap_ovf, loop_back;
    logic [CW-1:0]     remain, rp_next;
    logic [LANES-1:0]  rp_mask;
    logic              rp_wrap, fnsh_now, emit, rp_exit;
    logic              we;
    logic [CW-1:0]     wr_base;
    logic [BW-1:0]     rd_inst, rd_pc;

    assign out_free  = (ovld_q == '0) | out_rdy_in;
    assign stall     = ((ovld_q != '0) & !out_rdy_in)
                     | (state_q == ST_REPLAY);
    assign accept    = bndl_vld_in & !stall & !mis_pred_in;
    assign in_cnt    = mask2cnt(inst_valid_in);
    assign cap_sum   = {1'b0, wr_ptr_q} + (CW+1)'(in_cnt);
    assign cap_ovf   = cap_sum > (CW+1)'(DEPTH);
    assign loop_back = pc_in[BW-1 -: LANE_W] == spc_q;

    // A replay bundle stops at the end of the body, never straddling it.
    assign remain   = len_q - rd_ptr_q;
    assign rp_cnt   = (remain >= CW'(LANES)) ? 3'(LANES) : remain[2:0];
    assign rp_mask  = cnt2mask(rp_cnt);
    assign rp_next  = rd_ptr_q + CW'(rp_cnt);
    assign rp_wrap  = rp_next == len_q;
    assign fnsh_now = fnsh_q | fnsh_unrll_in;
    assign emit     = (state_q == ST_REPLAY) & out_free;
    assign rp_exit  = emit & rp_wrap & fnsh_now;

    lrb_mem #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_mem (
        .clk       (clk),
        .we_i      (we),
        .wr_ptr_i  (wr_base),
        .wr_mask_i (inst_valid_in),
        .wr_inst_i (inst_in),
        .wr_pc_i   (pc_in),
        .rd_ptr_i  (rd_ptr_q),
        .len_i     (len_q),
        .rd_inst_o (rd_inst),
        .rd_pc_o   (rd_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_PASS;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (mis_pred_in) begin
            state_d = ST_PASS;
        end else begin
            unique case (state_q)
                ST_PASS: begin
                    if (accept & loop_strt_in) state_d = ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (accept & loop_back)    state_d = ST_ARMED;
                    else if (accept & cap_ovf) state_d = ST_PASS;
                end
                ST_ARMED: begin
                    if (stll_ftch_in) state_d = ST_REPLAY;
                end
                ST_REPLAY: begin
                    if (rp_exit) state_d = ST_PASS;
                end
                default: state_d = ST_PASS;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        len_d    = len_q;
        spc_d    = spc_q;
        fnsh_d   = fnsh_q;
        we       = 1'b0;
        wr_base  = wr_ptr_q;
        if (mis_pred_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            len_d    = '0;
            fnsh_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_PASS: begin
                    if (accept & loop_strt_in) begin
                        we       = 1'b1;
                        wr_base  = '0;
                        wr_ptr_d = CW'(in_cnt);
                        spc_d    = pc_in[BW-1 -: LANE_W];
                    end
                end
                ST_CAPTURE: begin
                    if (accept & loop_back) begin
                        len_d = wr_ptr_q;
                    end else if (accept & cap_ovf) begin
                        wr_ptr_d = '0;
                    end else if (accept) begin
                        we       = 1'b1;
                        wr_ptr_d = cap_sum[CW-1:0];
                    end
                end
                ST_ARMED: begin
                    if (stll_ftch_in) begin
                        rd_ptr_d = '0;
                        fnsh_d   = 1'b0;
                    end
                end
                ST_REPLAY: begin
                    fnsh_d = fnsh_now;
                    if (emit) rd_ptr_d = rp_wrap ? '0 : rp_next;
                    if (rp_exit) begin
                        wr_ptr_d = '0;
                        len_d    = '0;
                        fnsh_d   = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        oinst_d = oinst_q;
        opc_d   = opc_q;
        ovld_d  = ovld_q;
        orep_d  = orep_q;
        done_d  = 1'b0;
        if (mis_pred_in) begin
            oinst_d = '0;
            opc_d   = '0;
            ovld_d  = '0;
            orep_d  = 1'b0;
        end else if (emit) begin
            oinst_d = rd_inst & lane_bits(rp_mask);
            opc_d   = rd_pc & lane_bits(rp_mask);
            ovld_d  = rp_mask;
            orep_d  = 1'b1;
            done_d  = rp_exit;
        end else if (out_free & accept) begin
            oinst_d = inst_in;
            opc_d   = pc_in;
            ovld_d  = inst_valid_in;
            orep_d  = 1'b0;
        end else if (out_free) begin
            oinst_d = '0;
            opc_d   = '0;
            ovld_d  = '0;
            orep_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            len_q    <= '0;
            spc_q    <= '0;
            fnsh_q   <= 1'b0;
            oinst_q  <= '0;
            opc_q    <= '0;
            ovld_q   <= '0;
            orep_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            len_q    <= len_d;
            spc_q    <= spc_d;
            fnsh_q   <= fnsh_d;
            oinst_q  <= oinst_d;
            opc_q    <= opc_d;
            ovld_q   <= ovld_d;
            orep_q   <= orep_d;
            done_q   <= done_d;
        end
    end

    assign out_inst      = oinst_q;
    assign out_pc        = opc_q;
    assign out_valid     = ovld_q;
    assign out_replay    = orep_q;
    assign ups_stall_out = stall;
    assign rply_done_out = done_q;

endmodule

// File: tb/tb_loop_replay_buf.sv
// Directed vector bench for loop_replay_buf: pass-through, backpressure,
// capture/replay, overflow, flush and simultaneity cases.
module tb_loop_replay_buf;

    localparam logic [63:0] XK = 64'hA5A5_5A5A_A5A5_5A5A;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bndl_vld_in = 1'b0;
    logic [63:0] inst_in = '0;
    logic [63:0] pc_in = '0;
    logic [3:0]  inst_valid_in = '0;
    logic        loop_strt_in = 1'b0;
    logic        stll_ftch_in = 1'b0;
    logic        fnsh_unrll_in = 1'b0;
    logic        mis_pred_in = 1'b0;
    logic        out_rdy_in = 1'b1;
    logic [63:0] out_inst;
    logic [63:0] out_pc;
    logic [3:0]  out_valid;
    logic        out_replay;
    logic        ups_stall_out;
    logic        rply_done_out;

    always #5 clk = ~clk;

    loop_replay_buf dut (
        .clk           (clk),
        .rst           (rst),
        .bndl_vld_in   (bndl_vld_in),
        .inst_in       (inst_in),
        .pc_in         (pc_in),
        .inst_valid_in (inst_valid_in),
        .loop_strt_in  (loop_strt_in),
        .stll_ftch_in  (stll_ftch_in),
        .fnsh_unrll_in (fnsh_unrll_in),
        .mis_pred_in   (mis_pred_in),
        .out_rdy_in    (out_rdy_in),
        .out_inst      (out_inst),
        .out_pc        (out_pc),
        .out_valid     (out_valid),
        .out_replay    (out_replay),
        .ups_stall_out (ups_stall_out),
        .rply_done_out (rply_done_out)
    );

    typedef struct {
        logic        vld;
        logic [15:0] pc;
        logic [3:0]  m;
        logic        ls, st, fn, mp, rdy;
        logic [3:0]  ev;
        logic [15:0] epc;
        logic        erep, estl, edone;
    } vec_t;

    vec_t vt[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [63:0] pcs(input logic [15:0] b);
        return {b, b + 16'd1, b + 16'd2, b + 16'd3};
    endfunction

    function automatic logic [63:0] lmask(input logic [3:0] m);
        return {{16{m[3]}}, {16{m[2]}}, {16{m[1]}}, {16{m[0]}}};
    endfunction

    function automatic vec_t mk(
        input logic vld, input logic [15:0] pc, input logic [3:0] m,
        input logic ls, input logic st, input logic fn, input logic mp,
        input logic rdy, input logic [3:0] ev, input logic [15:0] epc,
        input logic erep, input logic estl, input logic edone);
        vec_t r;
        r.vld = vld;   r.pc = pc;     r.m = m;
        r.ls = ls;     r.st = st;     r.fn = fn;
        r.mp = mp;     r.rdy = rdy;   r.ev = ev;
        r.epc = epc;   r.erep = erep; r.estl = estl;
        r.edone = edone;
        return r;
    endfunction

    task automatic drive(input vec_t t);
        bndl_vld_in   = t.vld;
        pc_in         = pcs(t.pc);
        inst_in       = pcs(t.pc) ^ XK;
        inst_valid_in = t.m;
        loop_strt_in  = t.ls;
        stll_ftch_in  = t.st;
        fnsh_unrll_in = t.fn;
        mis_pred_in   = t.mp;
        out_rdy_in    = t.rdy;
    endtask

    task automatic check(input int idx, input vec_t t);
        logic [63:0] lm;
        logic        ok;
        lm = lmask(t.ev);
        ok = (out_valid === t.ev)
           && ((out_pc & lm) === (pcs(t.epc) & lm))
           && ((out_inst & lm) === ((pcs(t.epc) ^ XK) & lm))
           && (out_replay === t.erep)
           && (ups_stall_out === t.estl)
           && (rply_done_out === t.edone);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL vec%0d got v=%b pc=%h rep=%b stl=%b dn=%b want v=%b pc0=%h rep=%b stl=%b dn=%b",
                     idx, out_valid, out_pc, out_replay, ups_stall_out,
                     rply_done_out, t.ev, t.epc, t.erep, t.estl, t.edone);
        end
    endtask

    initial begin
        // fields: vld pc m ls st fn mp rdy | ev epc rep stall done
        // first bundle after reset, then backpressure
        vt.push_back(mk(1, 16'h0000, 4'hE, 0,0,0,0,1, 4'hE, 16'h0000, 0,0,0));
        vt.push_back(mk(1, 16'h0010, 4'hF, 0,0,0,0,1, 4'hF, 16'h0010, 0,0,0));
        vt.push_back(mk(1, 16'h0020, 4'hF, 0,0,0,0,0, 4'hF, 16'h0010, 0,1,0));
        vt.push_back(mk(1, 16'h0020, 4'hF, 0,0,0,0,0, 4'hF, 16'h0010, 0,1,0));
        vt.push_back(mk(1, 16'h0020, 4'hF, 0,0,0,0,0, 4'hF, 16'h0010, 0,1,0));
        vt.push_back(mk(1, 16'h0020, 4'hF, 0,0,0,0,1, 4'hF, 16'h0020, 0,0,0));
        vt.push_back(mk(0, 16'h0000, 4'hF, 0,0,0,0,1, 4'h0, 16'h0000, 0,0,0));
        // 6-instruction body at 0x0100, fnsh mid-iteration
        vt.push_back(mk(1, 16'h0100, 4'hF, 1,0,0,0,1, 4'hF, 16'h0100, 0,0,0));
        vt.push_back(mk(1, 16'h0104, 4'hC, 0,0,0,0,1, 4'hC, 16'h0104, 0,0,0));
        vt.push_back(mk(1, 16'h0100, 4'hF, 0,0,0,0,1, 4'hF, 16'h0100, 0,0,0));
        vt.push_back(mk(0, 16'h0000, 4'hF, 0,1,0,0,1, 4'h0, 16'h0000, 0,1,0));
        vt.push_back(mk(0, 16'h0000, 4'hF, 0,1,0,0,1, 4'hF, 16'h0100, 1,1,0));
        vt.push_back(mk(1, 16'h0300, 4'hF, 0,1,0,0,1, 4'hC, 16'h0104, 1,1,0));
        vt.push_back(mk(0, 16'h0000, 4'hF, 0,0,1,0,1, 4'hF, 16'h0100, 1,1,0));
        vt.push_back(mk(0, 16'h0000, 4'hF, 0,0,0,0,1, 4'hC, 16'h0104, 1,0,1));
        vt.push_back(mk(0, 16'h0000, 4'hF, 0,0,0,0,1, 4'h0, 16'h0000, 0,0,0));
        vt.push_back(mk(1, 16'h0200, 4'hF, 0,1,0,0,1, 4'hF, 16'h0200, 0,0,0));
        // 5-instruction body, stall mid-replay, fnsh on final emit
        vt.push_back(mk(1, 16'h0400, 4'hF, 1,0,0,0,1, 4'hF, 16'h0400, 0,0,0));
        vt.push_back(mk(1, 16'h0404, 4'h8, 0,0,0,0,1, 4'h8, 16'h0404, 0,0,0));
        vt.push_back(mk(1, 16'h0400, 4'hE, 0,0,0,0,1, 4'hE, 16'h0400, 0,0,0));
        vt.push_back(mk(0, 16'h0000, 4'hF, 0,1,0,0,1, 4'h0, 16'h0000, 0,1,0));
        vt.push_back(mk(0, 16'h0000, 4'hF, 0,1,0,0,1, 4'hF, 16'h0400, 1,1,0));
        vt.push_back(mk(0, 16'h0000, 4'hF, 0,1,0,0,0, 4'hF, 16'h0400, 1,1,0));
        vt.push_back(mk(0, 16'h0000, 4'hF, 0,1,1,0,1, 4'h8, 16'h0404, 1,0,1));
        vt.push_back(mk(0, 16'h0000, 4'hF, 0,0,0,0,1, 4'h0, 16'h0000, 0,0,0));
        // flush at rd_ptr=4, then recapture from entry 0
        vt.push_back(mk(1, 16'h0500, 4'hF, 1,0,0,0,1, 4'hF, 16'h0500, 0,0,0));
        vt.push_back(mk(1, 16'h0504, 4'hC, 0,0,0,0,1, 4'hC, 16'h0504, 0,0,0));
        vt.push_back(mk(1, 16'h0500, 4'hF, 0,0,0,0,1, 4'hF, 16'h0500, 0,0,0));
        vt.push_back(mk(0, 16'h0000, 4'hF, 0,1,0,0,1, 4'h0, 16'h0000, 0,1,0));
        vt.push_back(mk(0, 16'h0000, 4'hF, 0,1,0,0,1, 4'hF, 16'h0500, 1,1,0));
        vt.push_back(mk(0, 16'h0000, 4'hF, 0,1,0,1,1, 4'h0, 16'h0000, 0,0,0));
        vt.push_back(mk(0, 16'h0000, 4'hF, 0,1,0,0,1, 4'h0, 16'h0000, 0,0,0));
        vt.push_back(mk(1, 16'h0600, 4'hF, 1,0,0,0,1, 4'hF, 16'h0600, 0,0,0));
        vt.push_back(mk(1, 16'h0604, 4'h8, 0,0,0,0,1, 4'h8, 16'h0604, 0,0,0));
        vt.push_back(mk(1, 16'h0600, 4'hF, 0,0,0,0,1, 4'hF, 16'h0600, 0,0,0));
        vt.push_back(mk(0, 16'h0000, 4'hF, 0,1,0,0,1, 4'h0, 16'h0000, 0,1,0));
        vt.push_back(mk(0, 16'h0000, 4'hF, 0,1,0,0,1, 4'hF, 16'h0600, 1,1,0));
        vt.push_back(mk(0, 16'h0000, 4'hF, 0,0,0,0,1, 4'h8, 16'h0604, 1,1,0));
        vt.push_back(mk(0, 16'h0000, 4'hF, 0,0,1,0,1, 4'hF, 16'h0600, 1,1,0));
        vt.push_back(mk(0, 16'h0000, 4'hF, 0,0,0,0,1, 4'h8, 16'h0604, 1,0,1));
        vt.push_back(mk(0, 16'h0000, 4'hF, 0,0,0,0,1, 4'h0, 16'h0000, 0,0,0));
        // loop start together with mispredict: no capture
        vt.push_back(mk(1, 16'h0700, 4'hF, 1,0,0,1,1, 4'h0, 16'h0000, 0,0,0));
        vt.push_back(mk(1, 16'h0704, 4'hF, 0,0,0,0,1, 4'hF, 16'h0704, 0,0,0));
        vt.push_back(mk(1, 16'h0700, 4'hF, 0,0,0,0,1, 4'hF, 16'h0700, 0,0,0));
        vt.push_back(mk(0, 16'h0000, 4'hF, 0,1,0,0,1, 4'h0, 16'h0000, 0,0,0));
        vt.push_back(mk(0, 16'h0000, 4'hF, 0,1,0,0,1, 4'h0, 16'h0000, 0,0,0));
        // 17 full bundles overflow a 64-entry buffer
        for (int i = 0; i < 17; i++) begin
            vt.push_back(mk(1, 16'h1000 + 16'(4*i), 4'hF, (i == 0),0,0,0,1,
                            4'hF, 16'h1000 + 16'(4*i), 0,0,0));
        end
        vt.push_back(mk(1, 16'h1000, 4'hF, 0,0,0,0,1, 4'hF, 16'h1000, 0,0,0));
        vt.push_back(mk(0, 16'h0000, 4'hF, 0,1,0,0,1, 4'h0, 16'h0000, 0,0,0));
        vt.push_back(mk(0, 16'h0000, 4'hF, 0,1,0,0,1, 4'h0, 16'h0000, 0,0,0));
        // exactly 64 instructions still fit and replay
        for (int i = 0; i < 16; i++) begin
            vt.push_back(mk(1, 16'h2000 + 16'(4*i), 4'hF, (i == 0),0,0,0,1,
                            4'hF, 16'h2000 + 16'(4*i), 0,0,0));
        end
        vt.push_back(mk(1, 16'h2000, 4'hF, 0,0,0,0,1, 4'hF, 16'h2000, 0,0,0));
        vt.push_back(mk(0, 16'h0000, 4'hF, 0,1,0,0,1, 4'h0, 16'h0000, 0,1,0));
        vt.push_back(mk(0, 16'h0000, 4'hF, 0,1,0,0,1, 4'hF, 16'h2000, 1,1,0));
        vt.push_back(mk(0, 16'h0000, 4'hF, 0,1,0,0,1, 4'hF, 16'h2004, 1,1,0));
        vt.push_back(mk(0, 16'h0000, 4'hF, 0,0,0,1,1, 4'h0, 16'h0000, 0,0,0));

        // reset held with inputs toggling
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bndl_vld_in   = 1'b1;
            pc_in         = pcs(16'h0F00);
            inst_in       = pcs(16'h0F00) ^ XK;
            inst_valid_in = 4'hF;
            loop_strt_in  = i[0];
            stll_ftch_in  = i[1];
            fnsh_unrll_in = i[0];
            out_rdy_in    = ~i[0];
            @(posedge clk);
            #1;
            total++;
            if (out_valid !== 4'h0 || ups_stall_out !== 1'b0
                || out_replay !== 1'b0 || rply_done_out !== 1'b0
                || out_pc !== 64'h0) begin
                bad++;
                $display("FAIL reset%0d got v=%b stl=%b rep=%b dn=%b want all 0",
                         i, out_valid, ups_stall_out, out_replay,
                         rply_done_out);
            end
        end

        rst = 1'b0;
        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i]);
            @(posedge clk);
            #1;
            check(i, vt[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
